clave_step_counter: RTL and testbench

Parametrised multi-step beat counter for the clave rhythm path, successor to the single-range clave counter. Counts qualified clock enables through a measure of `MAXCOUNT` counts split into equal steps, and emits a one-cycle `tick` at each step start. Adds pause/resume, loop or one-shot mode, and done/finished status. Sits between the rate divider, which drives `en`, and the pattern/LED/audio logic, which consumes `step` and `tick`.

---
 rtl/clave_step_counter_pkg.sv | 17 +
 rtl/clave_step_counter_step_div.sv | 31 +++
 rtl/clave_step_counter.sv | 115 +++++++++++
 tb/tb_clave_step_counter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/clave_step_counter_pkg.sv
// Shared definitions for the clave step counter: FSM state encodings and the
// default measure geometry used by the rate divider and pattern ROM as well.
package clave_step_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH    = 13;
  localparam int DEF_MAXCOUNT = 6600;
  localparam int DEF_STEP_LEN = 825;
  localparam int DEF_SW       = 3;

endpackage

// File: rtl/clave_step_counter_step_div.sv
// Step divider: counts 0..STEP_LEN-1 on adv and strobes wrap on the advance
// that leaves the last count of a step.
module clave_step_div #(
  parameter int STEP_LEN = 825
) (
  input  logic clk,
  input  logic resetn,
  input  logic adv,
  input  logic clr,
  output logic wrap
);

  localparam int CW = (STEP_LEN > 1) ? $clog2(STEP_LEN) : 1;

  logic [CW-1:0] r_cnt;

  assign wrap = adv && (r_cnt == CW'(STEP_LEN - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (adv) begin
      r_cnt <= wrap ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/clave_step_counter.sv
// Multi-step clave beat counter: counts qualified enables through a measure,
// emitting a tick at each step start and done at each measure end.
module clave_step_counter
  import clave_step_counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAXCOUNT = DEF_MAXCOUNT,
  parameter int STEP_LEN = DEF_STEP_LEN,
  parameter int SW       = DEF_SW
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic             en,
  input  logic             pause,
  input  logic             loop,
  output logic [WIDTH-1:0] count,
  output logic [SW-1:0]    step,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic             finished
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_adv;
  logic             w_meas_end;
  logic             w_clr;
  logic             w_wrap;
  logic [WIDTH-1:0] w_count_nxt;
  logic [SW-1:0]    w_step_nxt;
  logic             w_tick_nxt;
  logic             w_done_nxt;

  // go outranks pause, which outranks en; only RUN ever advances.
  assign w_adv      = (r_state == ST_RUN) && !go && !pause && en;
  assign w_meas_end = w_adv && (count == WIDTH'(MAXCOUNT - 1));
  assign w_clr      = go || w_meas_end;

  clave_step_div #(
    .STEP_LEN(STEP_LEN)
  ) u_step_div (
    .clk   (clk),
    .resetn(resetn),
    .adv   (w_adv),
    .clr   (w_clr),
    .wrap  (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      count    <= '0;
      step     <= '0;
      tick     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      count    <= w_count_nxt;
      step     <= w_step_nxt;
      tick     <= w_tick_nxt;
      done     <= w_done_nxt;
      busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
      finished <= (w_state_nxt == ST_DONE);
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (go) begin
      w_state_nxt = ST_RUN;
    end else begin
      unique case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_RUN: begin
          if (pause)                  w_state_nxt = ST_HOLD;
          else if (w_meas_end && !loop) w_state_nxt = ST_DONE;
        end
        // The resume cycle only changes state; counting restarts next cycle.
        ST_HOLD: if (!pause) w_state_nxt = ST_RUN;
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_count_nxt = count;
    w_step_nxt  = step;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    if (go) begin
      w_count_nxt = '0;
      w_step_nxt  = '0;
      w_tick_nxt  = 1'b1;
    end else if (w_meas_end) begin
      w_count_nxt = '0;
      w_step_nxt  = '0;
      w_done_nxt  = 1'b1;
      w_tick_nxt  = loop;
    end else if (w_adv) begin
      w_count_nxt = count + WIDTH'(1);
      if (w_wrap) begin
        w_step_nxt = step + SW'(1);
        w_tick_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clave_step_counter.sv
// Directed bench for clave_step_counter with a 12-count measure of 3 steps.
module tb_clave_step_counter;

  localparam int WIDTH    = 4;
  localparam int MAXCOUNT = 12;
  localparam int STEP_LEN = 4;
  localparam int SW       = 2;

  logic             clk = 1'b0;
  logic             resetn;
  logic             go;
  logic             en;
  logic             pause;
  logic             loop;
  logic [WIDTH-1:0] count;
  logic [SW-1:0]    step;
  logic             tick;
  logic             done;
  logic             busy;
  logic             finished;

  int n_checks = 0;
  int n_errors = 0;

  clave_step_counter #(
    .WIDTH   (WIDTH),
    .MAXCOUNT(MAXCOUNT),
    .STEP_LEN(STEP_LEN),
    .SW      (SW)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .go      (go),
    .en      (en),
    .pause   (pause),
    .loop    (loop),
    .count   (count),
    .step    (step),
    .tick    (tick),
    .done    (done),
    .busy    (busy),
    .finished(finished)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e_count, input int e_step,
                            input bit e_tick, input bit e_done, input bit e_busy,
                            input bit e_fin);
    check({tag, ".count"},    32'(count),    32'(e_count));
    check({tag, ".step"},     32'(step),     32'(e_step));
    check({tag, ".tick"},     32'(tick),     32'(e_tick));
    check({tag, ".done"},     32'(done),     32'(e_done));
    check({tag, ".busy"},     32'(busy),     32'(e_busy));
    check({tag, ".finished"}, 32'(finished), 32'(e_fin));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; go = 1'b1; en = 1'b0; pause = 1'b0; loop = 1'b1;

    // Reset overrides go, then idle ignores en.
    cycle(); cycle();
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    resetn = 1'b1; go = 1'b0; en = 1'b1; pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_outs($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0);
    end
    pause = 1'b0;

    // Looping measure.
    en = 1'b0; go = 1'b1;
    cycle();
    check_outs("loop_go", 0, 0, 1, 0, 1, 0);
    go = 1'b0; en = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      cycle();
      check_outs($sformatf("loop_en%0d", i), i % 12, (i % 12) / 4,
                 (i % 4) == 0, i == 12, 1, 0);
    end

    // One-shot measure.
    loop = 1'b0; en = 1'b0; go = 1'b1;
    cycle();
    check_outs("shot_go", 0, 0, 1, 0, 1, 0);
    go = 1'b0; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (i == 12) check_outs("shot_end", 0, 0, 0, 1, 0, 1);
      else check_outs($sformatf("shot_en%0d", i), i, i / 4, (i % 4) == 0, 0, 1, 0);
    end
    cycle();
    check_outs("done_hold", 0, 0, 0, 0, 0, 1);
    pause = 1'b1;
    cycle();
    check_outs("done_pause", 0, 0, 0, 0, 0, 1);
    pause = 1'b0;

    // go from DONE, then run to count 5 and pause there.
    loop = 1'b1; go = 1'b1; en = 1'b0;
    cycle();
    check_outs("done_go", 0, 0, 1, 0, 1, 0);
    go = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check_outs("pre_pause", 5, 1, 0, 0, 1, 0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_outs($sformatf("hold%0d", i), 5, 1, 0, 0, 1, 0);
    end
    pause = 1'b0;
    cycle();
    check_outs("resume1", 5, 1, 0, 0, 1, 0);
    cycle();
    check_outs("resume2", 6, 1, 0, 0, 1, 0);

    // Restart mid-measure at count 9.
    cycle(); cycle(); cycle();
    check_outs("pre_restart", 9, 2, 0, 0, 1, 0);
    go = 1'b1;
    cycle();
    check_outs("restart", 0, 0, 1, 0, 1, 0);
    go = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    check_outs("pre_reset", 7, 1, 0, 0, 1, 0);

    // Reset mid-run.
    resetn = 1'b0;
    cycle();
    check_outs("mid_reset", 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    cycle();
    check_outs("post_reset", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
